spi_slave_port: RTL and testbench

Byte-oriented SPI mode-0 slave (responder) for the 2-device SPI bus: receives MOSI bytes from the master and returns a byte on MISO in the same transfer. Runs entirely in the system clock domain, oversampling SCK/SS/MOSI. It presents the slave side of the SPI control handshake (toXmit/strobe in; Rcvd/Ready/XmitFull/busy out) to local system logic. One instance per slave device on the shared bus.

---
 rtl/spi_slave_port.sv | 152 +++++++++++++++
 tb/tb_spi_slave_port.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave port, oversampled in the clk domain, with transmit holding register.
// Define SPI_SLAVE_SYNC2_EN for two-flop input synchronizers (L=3); default single-flop capture (L=2).
module spi_slave_port #(
  parameter int unsigned SS_IDX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic [1:0] ss,
  inout  wire        miso,
  input  logic [7:0] toXmit,
  input  logic       strobe,
  output logic [7:0] Rcvd,
  output logic       Ready,
  output logic       XmitFull,
  output logic       busy
);

`ifdef SPI_SLAVE_SYNC2_EN
  localparam int unsigned DEPTH = 3;
`else
  localparam int unsigned DEPTH = 2;
`endif

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e         state_q, state_d;
  logic [DEPTH:0] sck_sr_q, sck_sr_d;
  logic [DEPTH:0] mosi_sr_q, mosi_sr_d;
  logic [DEPTH:0] ss_sr_q, ss_sr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     rx_q, rx_d;
  logic [7:0]     tx_q, tx_d;
  logic [7:0]     hold_q, hold_d;
  logic [7:0]     rcvd_q, rcvd_d;
  logic           full_q, full_d;
  logic           ready_q, ready_d;
  logic           load;
  logic           sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
  logic           busy_o, miso_o;
  logic           unused_ss;

  assign unused_ss = ^ss;

  // Stage DEPTH-1 is the synchronized value, stage DEPTH its one-cycle-old copy for edge detect.
  always_comb begin
    sck_sr_d  = {sck_sr_q[DEPTH-1:0], sck};
    mosi_sr_d = {mosi_sr_q[DEPTH-1:0], mosi};
    ss_sr_d   = {ss_sr_q[DEPTH-1:0], ss[SS_IDX]};
    sck_rise  =  sck_sr_q[DEPTH-1] & ~sck_sr_q[DEPTH];
    sck_fall  = ~sck_sr_q[DEPTH-1] &  sck_sr_q[DEPTH];
    ss_fall   = ~ss_sr_q[DEPTH-1]  &  ss_sr_q[DEPTH];
    ss_rise   =  ss_sr_q[DEPTH-1]  & ~ss_sr_q[DEPTH];
    mosi_s    =  mosi_sr_q[DEPTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sck_sr_q  <= '0;
      mosi_sr_q <= '0;
      ss_sr_q   <= '1;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      hold_q    <= '0;
      rcvd_q    <= '0;
      full_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_sr_q  <= sck_sr_d;
      mosi_sr_q <= mosi_sr_d;
      ss_sr_q   <= ss_sr_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      hold_q    <= hold_d;
      rcvd_q    <= rcvd_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    hold_d  = hold_q;
    rcvd_d  = rcvd_q;
    full_d  = full_q;
    ready_d = 1'b0;
    load    = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        cnt_d = '0;
        load  = 1'b1;
      end
    end else if (ss_rise) begin
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = '0;
    end else if (sck_rise) begin
      rx_d  = {rx_q[6:0], mosi_s};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rcvd_d  = {rx_q[6:0], mosi_s};
        ready_d = 1'b1;
        load    = 1'b1;
      end
    end else if (sck_fall && cnt_q != 3'd0) begin
      tx_d = {tx_q[6:0], 1'b0};
    end

    // A load consumes the holding register first; strobe only bypasses when it is empty.
    if (load) begin
      if (full_q) begin
        tx_d   = hold_q;
        full_d = 1'b0;
      end else if (strobe) begin
        tx_d = toXmit;
      end else begin
        tx_d = '0;
      end
    end else if (strobe && !full_q) begin
      hold_d = toXmit;
      full_d = 1'b1;
    end
  end

  always_comb begin
    busy_o = (state_q == ACTIVE);
    miso_o = tx_q[7];
  end

  assign miso     = busy_o ? miso_o : 1'bz;
  assign busy     = busy_o;
  assign Rcvd     = rcvd_q;
  assign Ready    = ready_q;
  assign XmitFull = full_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: table of single-byte transfers plus multi-cycle corner sequences.
module tb_spi_slave_port;

`ifdef SPI_SLAVE_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       mosi;
  logic [1:0] ss;
  logic [7:0] toXmit;
  logic       strobe;
  logic [7:0] Rcvd;
  logic       Ready;
  logic       XmitFull;
  logic       busy;
  wire        miso_w;

  pullup (miso_w);

  spi_slave_port #(.SS_IDX(0)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss), .miso(miso_w),
    .toXmit(toXmit), .strobe(strobe), .Rcvd(Rcvd), .Ready(Ready),
    .XmitFull(XmitFull), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_ready = 0;

  always @(negedge clk) if (Ready) n_ready++;

  typedef struct {
    logic [7:0] mo;
    logic       pre_en;
    logic [7:0] pre_val;
    logic [7:0] exp_mi;
  } vec_t;

  vec_t vecs [5];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_strobe(input logic [7:0] v);
    toXmit = v;
    strobe = 1'b1;
    wait_clk(1);
    strobe = 1'b0;
  endtask

  // Master side of one byte (or the first nbits); optional strobes during the low phase of given bits.
  task automatic xfer_byte(input logic [7:0] mo, input int nbits,
                           input int st1_bit, input logic [7:0] st1_val,
                           input int st2_bit, input logic [7:0] st2_val,
                           output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      if (i == st1_bit) begin
        do_strobe(st1_val);
        wait_clk(H - 1);
      end else if (i == st2_bit) begin
        do_strobe(st2_val);
        wait_clk(H - 1);
      end else begin
        wait_clk(H);
      end
      mi[i] = miso_w;
      sck = 1'b1;
      wait_clk(H);
      sck = 1'b0;
    end
    wait_clk(H);
  endtask

  task automatic run_xfer(input string name, input logic [7:0] mo, input logic pre_en,
                          input logic [7:0] pre_val, input logic [7:0] exp_mi);
    logic [7:0] mi;
    int r0;
    if (pre_en) begin
      do_strobe(pre_val);
      chk({name, "_full_pre"}, {7'd0, XmitFull}, 8'd1);
    end
    r0 = n_ready;
    ss[0] = 1'b0;
    wait_clk(H);
    chk({name, "_busy"}, {7'd0, busy}, 8'd1);
    chk({name, "_full_load"}, {7'd0, XmitFull}, 8'd0);
    xfer_byte(mo, 8, -1, 8'h00, -1, 8'h00, mi);
    chk({name, "_miso"}, mi, exp_mi);
    chk({name, "_rcvd"}, Rcvd, mo);
    chk({name, "_ready"}, 8'(n_ready - r0), 8'd1);
    ss[0] = 1'b1;
    wait_clk(H);
    chk({name, "_idle"}, {7'd0, busy}, 8'd0);
    chk({name, "_z"}, {7'd0, miso_w}, 8'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mi;
    int r0;

    vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{8'h5A, 1'b1, 8'h3C, 8'h3C};
    vecs[2] = '{8'hC3, 1'b1, 8'h96, 8'h96};
    vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{8'h00, 1'b1, 8'h81, 8'h81};

    rst = 1'b1; ss = 2'b11; sck = 1'b0; mosi = 1'b0; strobe = 1'b0; toXmit = '0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    chk("rst_rcvd", Rcvd, 8'h00);
    chk("rst_ready", {7'd0, Ready}, 8'd0);
    chk("rst_full", {7'd0, XmitFull}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_z", {7'd0, miso_w}, 8'd1);

    for (int v = 0; v < 5; v++)
      run_xfer($sformatf("vec%0d", v), vecs[v].mo, vecs[v].pre_en, vecs[v].pre_val, vecs[v].exp_mi);

    // Two bytes under one select; strobe 22 refills holding, strobe 33 hits a full register.
    do_strobe(8'h11);
    r0 = n_ready;
    ss[0] = 1'b0;
    wait_clk(H);
    xfer_byte(8'h69, 8, 5, 8'h22, 3, 8'h33, mi);
    chk("two_b1_miso", mi, 8'h11);
    chk("two_b1_rcvd", Rcvd, 8'h69);
    chk("two_b1_full", {7'd0, XmitFull}, 8'd0);
    xfer_byte(8'h96, 8, -1, 8'h00, -1, 8'h00, mi);
    chk("two_b2_miso", mi, 8'h22);
    chk("two_b2_rcvd", Rcvd, 8'h96);
    chk("two_ready", 8'(n_ready - r0), 8'd2);
    ss[0] = 1'b1;
    wait_clk(H);

    // Abort after 5 rises; holding filled mid-byte must survive.
    r0 = n_ready;
    ss[0] = 1'b0;
    wait_clk(H);
    xfer_byte(8'hF0, 5, 6, 8'h44, -1, 8'h00, mi);
    ss[0] = 1'b1;
    wait_clk(H);
    chk("abort_ready", 8'(n_ready - r0), 8'd0);
    chk("abort_rcvd", Rcvd, 8'h96);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_full", {7'd0, XmitFull}, 8'd1);
    run_xfer("post_abort", 8'h3A, 1'b0, 8'h00, 8'h44);

    // Other slave selected: this port must stay idle.
    r0 = n_ready;
    ss = 2'b01;
    wait_clk(H);
    xfer_byte(8'hB7, 8, -1, 8'h00, -1, 8'h00, mi);
    chk("other_busy", {7'd0, busy}, 8'd0);
    chk("other_z", {7'd0, miso_w}, 8'd1);
    chk("other_ready", 8'(n_ready - r0), 8'd0);
    chk("other_rcvd", Rcvd, 8'h3A);
    ss = 2'b11;
    wait_clk(H);

    // Strobe sampled on the same edge as the select load: bypass into the shifter.
    ss[0] = 1'b0;
    wait_clk(LAT);
    do_strobe(8'h7E);
    chk("byp_full", {7'd0, XmitFull}, 8'd0);
    wait_clk(H - LAT - 1);
    xfer_byte(8'h18, 8, -1, 8'h00, -1, 8'h00, mi);
    chk("byp_miso", mi, 8'h7E);
    chk("byp_rcvd", Rcvd, 8'h18);
    ss[0] = 1'b1;
    wait_clk(H);

    // Asynchronous reset in the middle of a byte.
    do_strobe(8'h55);
    ss[0] = 1'b0;
    wait_clk(H);
    xfer_byte(8'hE1, 3, -1, 8'h00, -1, 8'h00, mi);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rcvd", Rcvd, 8'h00);
    chk("mid_rst_ready", {7'd0, Ready}, 8'd0);
    chk("mid_rst_full", {7'd0, XmitFull}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_z", {7'd0, miso_w}, 8'd1);
    ss = 2'b11;
    sck = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(H);
    run_xfer("post_rst", 8'hC3, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
